// File: rtl/sysid_read_arbiter.sv
// Round-robin arbiter sharing one read-only ID slave among NUM_REQ requesters.
// One read in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module sysid_read_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 1,
  parameter int DATA_W    = 32,
  parameter int SLAVE_LAT = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [NUM_REQ-1:0]        last_grant,
  output logic [ADDR_W-1:0]         slv_address,
  output logic                      slv_read,
  input  logic [DATA_W-1:0]         slv_readdata
);

  localparam int          IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR    = NUM_REQ;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_grant, w_grant_nxt;
  logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
  logic [2:0]          r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]  r_ack, w_ack_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_busy;
  logic [NUM_REQ-1:0]  r_last_grant, w_last_grant_nxt;
  logic [ADDR_W-1:0]   r_slv_address, w_slv_address_nxt;
  logic                r_slv_read, w_slv_read_nxt;

  logic                w_found;
  logic [IDX_W-1:0]    w_sel;
  logic [IDX_W-1:0]    w_sel_ptr;
  logic [ADDR_W-1:0]   w_sel_addr;
  int unsigned         w_idx;

  // Scan upward from r_ptr with wrap; first set request wins.
  always_comb begin
    w_found    = 1'b0;
    w_sel      = '0;
    w_sel_ptr  = '0;
    w_sel_addr = '0;
    w_idx      = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      w_idx = 32'(r_ptr) + k;
      if (w_idx >= NR) w_idx = w_idx - NR;
      if (!w_found && req[IDX_W'(w_idx)]) begin
        w_found    = 1'b1;
        w_sel      = IDX_W'(w_idx);
        w_sel_addr = req_addr[w_idx*ADDR_W +: ADDR_W];
        w_sel_ptr  = (w_idx + 1 == NR) ? '0 : IDX_W'(w_idx + 1);
      end
    end
  end

  // Port values are computed one state ahead so every output comes from a flop.
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_ptr_nxt         = r_ptr;
    w_cnt_nxt         = r_cnt;
    w_ack_nxt         = '0;
    w_rdata_nxt       = r_rdata;
    w_last_grant_nxt  = r_last_grant;
    w_slv_address_nxt = r_slv_address;
    w_slv_read_nxt    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt              = w_sel;
          w_ptr_nxt                = w_sel_ptr;
          w_last_grant_nxt         = '0;
          w_last_grant_nxt[w_sel]  = 1'b1;
          w_slv_address_nxt        = w_sel_addr;
          w_slv_read_nxt           = 1'b1;
          w_state_nxt              = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_cnt_nxt   = 3'(SLAVE_LAT);
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_rdata_nxt        = slv_readdata;
          w_ack_nxt[r_grant] = 1'b1;
          w_state_nxt        = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_ack         <= '0;
      r_rdata       <= '0;
      r_busy        <= 1'b0;
      r_last_grant  <= '0;
      r_slv_address <= '0;
      r_slv_read    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_ptr         <= w_ptr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_ack         <= w_ack_nxt;
      r_rdata       <= w_rdata_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_last_grant  <= w_last_grant_nxt;
      r_slv_address <= w_slv_address_nxt;
      r_slv_read    <= w_slv_read_nxt;
    end
  end

  assign ack         = r_ack;
  assign rdata       = r_rdata;
  assign busy        = r_busy;
  assign last_grant  = r_last_grant;
  assign slv_address = r_slv_address;
  assign slv_read    = r_slv_read;

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Directed bench for sysid_read_arbiter: per-cycle vector table on a SLAVE_LAT=0
// instance plus hand sequences for back-to-back, SLAVE_LAT=2 and mid-read reset.
module tb_sysid_read_arbiter;

  localparam logic [31:0] D0   = 32'hACD51302;
  localparam logic [31:0] D1   = 32'h5733DC2A;
  localparam logic [31:0] DBAD = 32'hDEADBEEF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: SLAVE_LAT=0
  logic        a_rst;
  logic [1:0]  a_req, a_addr, a_ack, a_lg;
  logic [31:0] a_rdata, a_srd;
  logic        a_busy, a_saddr, a_sread;
  // Instance B: SLAVE_LAT=2
  logic        b_rst;
  logic [1:0]  b_req, b_addr, b_ack, b_lg;
  logic [31:0] b_rdata, b_srd;
  logic        b_busy, b_saddr, b_sread;
  logic [2:0]  b_age;
  // Instance C: SLAVE_LAT=3
  logic        c_rst;
  logic [1:0]  c_req, c_addr, c_ack, c_lg;
  logic [31:0] c_rdata, c_srd;
  logic        c_busy, c_saddr, c_sread;

  sysid_read_arbiter #(.NUM_REQ(2), .ADDR_W(1), .DATA_W(32), .SLAVE_LAT(0)) u_a (
    .clock(clock), .reset(a_rst), .req(a_req), .req_addr(a_addr), .ack(a_ack),
    .rdata(a_rdata), .busy(a_busy), .last_grant(a_lg), .slv_address(a_saddr),
    .slv_read(a_sread), .slv_readdata(a_srd));

  sysid_read_arbiter #(.NUM_REQ(2), .ADDR_W(1), .DATA_W(32), .SLAVE_LAT(2)) u_b (
    .clock(clock), .reset(b_rst), .req(b_req), .req_addr(b_addr), .ack(b_ack),
    .rdata(b_rdata), .busy(b_busy), .last_grant(b_lg), .slv_address(b_saddr),
    .slv_read(b_sread), .slv_readdata(b_srd));

  sysid_read_arbiter #(.NUM_REQ(2), .ADDR_W(1), .DATA_W(32), .SLAVE_LAT(3)) u_c (
    .clock(clock), .reset(c_rst), .req(c_req), .req_addr(c_addr), .ack(c_ack),
    .rdata(c_rdata), .busy(c_busy), .last_grant(c_lg), .slv_address(c_saddr),
    .slv_read(c_sread), .slv_readdata(c_srd));

  // Slave models
  assign a_srd = a_saddr ? D1 : D0;
  assign c_srd = c_saddr ? D1 : D0;

  // Slow slave: garbage until two cycles after the read strobe
  always @(posedge clock) begin
    if (b_rst)                               b_age <= 3'd0;
    else if (b_sread)                        b_age <= 3'd1;
    else if (b_age != 3'd0 && b_age != 3'd7) b_age <= b_age + 3'd1;
  end
  assign b_srd = (b_age >= 3'd2) ? (b_saddr ? D1 : D0) : DBAD;

  int n_cmp = 0;
  int n_bad = 0;
  int nrd   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  addr;
    logic [1:0]  ack;
    logic        busy;
    logic        rd;
    logic        sa;
    logic [31:0] rdata;
    logic [1:0]  lg;
  } vec_t;

  vec_t vt[27];

  initial begin
    a_rst = 1'b1; a_req = 2'b00; a_addr = 2'b00;
    b_rst = 1'b1; b_req = 2'b00; b_addr = 2'b00;
    c_rst = 1'b1; c_req = 2'b00; c_addr = 2'b00;

    //              rst   req    addr   ack    busy  rd    sa    rdata   lg
    // reset held with requests present
    vt[0]  = '{1'b1, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00};
    vt[1]  = '{1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00};
    vt[2]  = '{1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00};
    // single read: req0 addr0, dropped in its ack cycle
    vt[3]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00};
    vt[4]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0, 2'b01};
    vt[5]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 2'b01};
    vt[6]  = '{1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, D0,    2'b01};
    vt[7]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, D0,    2'b01};
    // re-reset, then contention: req0 addr1, req1 addr0
    vt[8]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, D0,    2'b01};
    vt[9]  = '{1'b0, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00};
    vt[10] = '{1'b0, 2'b11, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0, 2'b01};
    vt[11] = '{1'b0, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0, 2'b01};
    vt[12] = '{1'b0, 2'b10, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1, D1,    2'b01};
    // req0 re-raised in the IDLE cycle; req1 still goes first
    vt[13] = '{1'b0, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, D1,    2'b01};
    vt[14] = '{1'b0, 2'b11, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, D1,    2'b10};
    vt[15] = '{1'b0, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, D1,    2'b10};
    vt[16] = '{1'b0, 2'b01, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, D0,    2'b10};
    // req1 re-raised; pending req0 wins this round
    vt[17] = '{1'b0, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, D0,    2'b10};
    vt[18] = '{1'b0, 2'b11, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, D0,    2'b01};
    vt[19] = '{1'b0, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, D0,    2'b01};
    vt[20] = '{1'b0, 2'b10, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1, D1,    2'b01};
    vt[21] = '{1'b0, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, D1,    2'b01};
    vt[22] = '{1'b0, 2'b10, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, D1,    2'b10};
    vt[23] = '{1'b0, 2'b10, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, D1,    2'b10};
    vt[24] = '{1'b0, 2'b00, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, D0,    2'b10};
    vt[25] = '{1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, D0,    2'b10};
    vt[26] = '{1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, D0,    2'b10};

    for (int i = 0; i < 27; i++) begin
      @(posedge clock); #1;
      a_rst = vt[i].rst; a_req = vt[i].req; a_addr = vt[i].addr;
      @(negedge clock);
      chk($sformatf("vec%0d.ack", i),   32'(a_ack),   32'(vt[i].ack));
      chk($sformatf("vec%0d.busy", i),  32'(a_busy),  32'(vt[i].busy));
      chk($sformatf("vec%0d.read", i),  32'(a_sread), 32'(vt[i].rd));
      chk($sformatf("vec%0d.saddr", i), 32'(a_saddr), 32'(vt[i].sa));
      chk($sformatf("vec%0d.rdata", i), a_rdata,      vt[i].rdata);
      chk($sformatf("vec%0d.lgrant", i), 32'(a_lg),   32'(vt[i].lg));
    end

    // Back-to-back: req1 (addr1) held continuously
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      a_req = 2'b10; a_addr = 2'b10;
      @(negedge clock);
      chk($sformatf("b2b%0d.ack", k),  32'(a_ack),   (k % 4 == 3) ? 32'h2 : 32'h0);
      chk($sformatf("b2b%0d.read", k), 32'(a_sread), (k % 4 == 1) ? 32'h1 : 32'h0);
      chk($sformatf("b2b%0d.busy", k), 32'(a_busy),  (k % 4 != 0) ? 32'h1 : 32'h0);
      if (k % 4 == 3) chk($sformatf("b2b%0d.rdata", k), a_rdata, D1);
      if (a_sread) nrd++;
    end
    chk("b2b.read_count", 32'(nrd), 32'd3);
    @(posedge clock); #1;
    a_req = 2'b00;

    // SLAVE_LAT=2: early garbage must never be captured
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      b_rst = 1'b0; b_req = (k <= 5) ? 2'b01 : 2'b00; b_addr = 2'b00;
      @(negedge clock);
      chk($sformatf("lat%0d.ack", k),   32'(b_ack),   (k == 5) ? 32'h1 : 32'h0);
      chk($sformatf("lat%0d.read", k),  32'(b_sread), (k == 1) ? 32'h1 : 32'h0);
      chk($sformatf("lat%0d.busy", k),  32'(b_busy),  (k >= 1 && k <= 5) ? 32'h1 : 32'h0);
      chk($sformatf("lat%0d.rdata", k), b_rdata,      (k >= 5) ? D0 : 32'h0);
    end

    // SLAVE_LAT=3: reset in WAIT aborts the read without an ack
    for (int k = 0; k < 11; k++) begin
      @(posedge clock); #1;
      c_rst = (k == 3); c_req = (k < 3) ? 2'b01 : 2'b00; c_addr = 2'b10;
      @(negedge clock);
      chk($sformatf("mrst%0d.ack", k),    32'(c_ack),  32'h0);
      chk($sformatf("mrst%0d.busy", k),   32'(c_busy), (k >= 1 && k <= 3) ? 32'h1 : 32'h0);
      chk($sformatf("mrst%0d.lgrant", k), 32'(c_lg),   (k >= 1 && k <= 3) ? 32'h1 : 32'h0);
      chk($sformatf("mrst%0d.rdata", k),  c_rdata,     32'h0);
    end

    // After reset, simultaneous req0/req1: req0 must win
    for (int j = 0; j < 8; j++) begin
      @(posedge clock); #1;
      c_req = (j <= 6) ? 2'b11 : 2'b00; c_addr = 2'b10;
      @(negedge clock);
      chk($sformatf("prst%0d.ack", j), 32'(c_ack), (j == 6) ? 32'h1 : 32'h0);
      if (j == 1) begin
        chk("prst1.lgrant", 32'(c_lg),    32'h1);
        chk("prst1.saddr",  32'(c_saddr), 32'h0);
        chk("prst1.read",   32'(c_sread), 32'h1);
      end
      if (j == 6) chk("prst6.rdata", c_rdata, D0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
